// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (8 data bits, LSB first, optional parity)
//          that pushes each received byte plus its error flags into an RX FIFO.
//
// Parameters
//   CLK_FREQ       informational system clock frequency; no logic depends on it
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rx             asynchronous serial input, idle high
//   baud_divisor   clocks per bit (>= 4), captured at the start of each frame
//   i_parity_type  00 none, 01 even, 11 odd, 10 mark; captured with the divisor
//   i_fifo_full    RX FIFO full, sampled in the stop-bit sample cycle
//   o_fifo_wr_en   one-cycle FIFO write strobe
//   o_fifo_wdata   {frame_err, parity_err, data[7:0]}, valid with o_fifo_wr_en
//   o_overrun      one-cycle pulse when a frame completes while the FIFO is full
//   o_busy         high whenever the receiver is not idle
//
// Build option
//   UART_RX_MAJORITY_EN  each bit is the 2-of-3 majority of the synchronised
//                        line around the sample point; the decision (and the
//                        write strobe) lands one clock later.
module uart_rx #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [15:0] baud_divisor,
    input  logic [1:0]  i_parity_type,
    input  logic        i_fifo_full,
    output logic        o_fifo_wr_en,
    output logic [9:0]  o_fifo_wdata,
    output logic        o_overrun,
    output logic        o_busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    if (CLK_FREQ <= 0) begin : g_bad_clk_freq
        $error("uart_rx: CLK_FREQ must be positive");
    end

    logic        rx_meta_q, rx_s_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  ptype_q, ptype_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_err_q, parity_err_d;
    logic        wr_en_q, wr_en_d;
    logic        overrun_q, overrun_d;
    logic [9:0]  wdata_q, wdata_d;
    logic [15:0] sp;
    logic        tick;
    logic        bit_val;
    logic        exp_par;

    // START samples at mid-bit; every later bit is one full divisor after that.
    assign sp = (state_q == S_START) ? (div_q >> 1) - 16'd1 : div_q - 16'd1;

`ifdef UART_RX_MAJORITY_EN
    // Two previous synchronised samples: hist_q[0] was taken at sp, hist_q[1]
    // at sp-1 when the decision is made at sp+1.
    logic [1:0] hist_q;
    // The counter is reloaded to 1 rather than 0 because the decision is made a
    // clock late; this keeps every sample window centred on the same bit grid
    // as the single-sample build, so bit spacing stays exactly div.
    localparam logic [15:0] CNT_RELOAD = 16'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 2'b11;
        else        hist_q <= {hist_q[0], rx_s_q};
    end
    assign tick    = clk_cnt_q == sp + 16'd1;
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    localparam logic [15:0] CNT_RELOAD = 16'd0;
    assign tick    = clk_cnt_q == sp;
    assign bit_val = rx_s_q;
`endif

    // Even is ^data, odd is its inverse (ptype[1] set), mark is constant 1.
    assign exp_par = (ptype_q == 2'b10) ? 1'b1 : ((^shift_q) ^ ptype_q[1]);

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = tick ? CNT_RELOAD : clk_cnt_q + 16'd1;
        div_d        = div_q;
        ptype_d      = ptype_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_err_d = parity_err_q;
        wr_en_d      = 1'b0;
        overrun_d    = 1'b0;
        wdata_d      = wdata_q;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d      = S_START;
                    div_d        = baud_divisor;
                    ptype_d      = i_parity_type;
                    parity_err_d = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = bit_val ? S_IDLE : S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {bit_val, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = (ptype_q == 2'b00) ? S_STOP : S_PARITY;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    parity_err_d = bit_val != exp_par;
                    state_d      = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    wr_en_d   = !i_fifo_full;
                    overrun_d = i_fifo_full;
                    if (!i_fifo_full) wdata_d = {~bit_val, (ptype_q != 2'b00) & parity_err_q, shift_q};
                    // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
                    state_d   = bit_val ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // A line held low must not retrigger a frame until it recovers.
                clk_cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            div_q        <= '0;
            ptype_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_err_q <= 1'b0;
            wr_en_q      <= 1'b0;
            overrun_q    <= 1'b0;
            wdata_q      <= '0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            div_q        <= div_d;
            ptype_q      <= ptype_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_err_q <= parity_err_d;
            wr_en_q      <= wr_en_d;
            overrun_q    <= overrun_d;
            wdata_q      <= wdata_d;
        end
    end

    assign o_fifo_wr_en = wr_en_q;
    assign o_fifo_wdata = wdata_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = state_q != S_IDLE;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage paired with the transmitter. Oversamples the serial `rx` line with the same clocks-per-bit divisor and parity encoding as the transmitter, and deserialises frames of 8 data bits, LSB first. Each received byte, with its error flags, is pushed into a downstream RX FIFO through a write-enable/full handshake. Sits between the board pin (or a TX loopback) and the RX FIFO.

## Interface
- `CLK_FREQ`, 50000000: informational only; no logic depends on it.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx` in 1: asynchronous serial input; idle high.
- `baud_divisor` in 16: clocks per bit; legal range ≥ 4, smaller values undefined.
- `i_parity_type` in 2: 00 none, 01 even (bit = ^data), 11 odd (bit = ~^data), 10 mark (bit must be 1).
- `i_fifo_full` in 1: RX FIFO full.
- `o_fifo_wr_en` out 1: one-cycle write strobe.
- `o_fifo_wdata` out 10: {frame_err, parity_err, data[7:0]}; valid while `o_fifo_wr_en` is high.
- `o_overrun` out 1: one-cycle pulse when a frame completes while `i_fifo_full` is high.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser to give `rx_s`. Both flops reset to 1.
- Counter `clk_cnt` is 16 bits. Sample point `sp`:
  - `(div>>1)-1` in START.
  - `div-1` in all other bit states.
  - When `clk_cnt == sp`, the bit is sampled, `clk_cnt` clears, and the state advances. Otherwise `clk_cnt` increments.
- `div` and `ptype` are registered copies of `baud_divisor` and `i_parity_type`. They are captured on the IDLE→START transition and held for the whole frame; input changes mid-frame have no effect.
- States:
  - IDLE: `clk_cnt=0`. If `rx_s==0`, capture `div`/`ptype` and go to START.
  - START: at `sp`, if the sample is 1 (glitch), go to IDLE with no write. If 0, go to DATA with `bit_cnt=0`.
  - DATA: at `sp`, shift the sample into `shift[7]` (right shift). On the 8th bit, go to STOP if `ptype==00`, else PARITY.
  - PARITY: at `sp`, `parity_err = (sample != expected)`. Go to STOP.
  - STOP: at `sp`, `frame_err = ~sample`. Issue the write/overrun for this frame. Go to IDLE if the sample is 1, else BREAK.
  - BREAK: stay until `rx_s==1`, then go to IDLE. This prevents a low line from retriggering a frame.
- Write issue, registered, one cycle after the STOP sample:
  - If `!i_fifo_full` (sampled in the STOP sample cycle): `o_fifo_wr_en=1`, `o_fifo_wdata={frame_err, parity_err, shift}`.
  - Else: `o_overrun=1`, no write, data dropped.
- Frames with errors are still written; the flags travel in `wdata[9:8]`.
- `parity_err` is forced to 0 when `ptype==00`.
- Return to IDLE occurs at mid-stop-bit, so back-to-back frames from the transmitter are received without loss.

## Timing
- Reset values:
  - `o_fifo_wr_en=0`, `o_fifo_wdata=0`, `o_overrun=0`, `o_busy=0`.
  - State IDLE, `clk_cnt=0`, `shift=0`, synchroniser flops = 1.
- `rx` → `rx_s` latency: 2 clocks. IDLE→START on the clock after `rx_s` goes low.
- STOP sample lands at `(div>>1) + (9 or 10)·div` clocks after entering START. Write strobe follows 1 clock later.
- Required bit tolerance: sampling at mid-bit accepts ±(div/2−2) clocks of cumulative drift per frame.
- `o_fifo_wr_en` and `o_overrun` are mutually exclusive; each is high for exactly 1 clock per frame.
- `rst_n` asserted mid-frame: immediate return to reset values. The partial frame is discarded; no write, no overrun.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit value is the 2-of-3 majority of `rx_s` at `clk_cnt == sp-1, sp, sp+1`.
  - The decision is taken at `sp+1`, and the counter is cleared at `sp+1`, so bit spacing stays `div`.
  - The write strobe occurs 1 clock later than without the macro.
  - The START glitch check also uses the majority.
- Not defined: single sample at `sp`; no extra flops.

## Test plan
- `div=16`, `ptype=00`, transmit 0xA5 with a 1-bit stop → exactly one `wr_en`, `wdata=0x0A5`, `o_overrun=0`, `o_busy` returns to 0.
- `div=16`, `ptype=01`, send 0x03 with parity bit 1 (wrong; correct is 0) → `wdata=0x103`. Repeat with parity bit 0 → `wdata=0x003`.
- `div=16`, send 0x55 with stop bit driven 0, then hold `rx` low for 40 clocks → `wdata=0x255`, FSM held in BREAK, no second write until `rx` rises and a fresh start bit arrives.
- `div=16`, `rx` low pulse of 4 clocks → no write, `o_overrun=0`, FSM back in IDLE with `o_busy=0` before `clk_cnt` reaches 16.
- `div=16`, `i_fifo_full=1` during the stop bit of 0x3C → `o_overrun` one-cycle pulse, `o_fifo_wr_en` stays 0. Next frame 0xC3 with full=0 → `wdata=0x0C3`.
- Loopback from the transmitter, `div=16`, `ptype=11`, 4 back-to-back bytes 0x00, 0xFF, 0x81, 0x7E → four writes in order, all flags 0. Assert `rst_n` mid-second-byte → no write for the aborted byte, clean receipt of the next byte.
